// File: rtl/ram_bist_if.sv
// rtl/ram_bist_if.sv - single-port RAM bus between the BIST engine and the RAM under test
interface ram_bist_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;

    modport master (output wea, addra, dina, input douta);
    modport slave  (input wea, addra, dina, output douta);
endinterface

// File: rtl/ram_bist.sv
// rtl/ram_bist.sv - write/gap/read RAM self-test engine; define RAM_BIST_ERR_LOG_EN for first-mismatch capture
module ram_bist #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int GAP    = 68
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    ram_bist_if.master        ram,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data
);
    localparam int WC_W = $clog2(GAP + RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_GAP, S_READ, S_DRAIN, S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_cnt;
    logic [WC_W-1:0]   wait_cnt;
    logic [1:0]        mode_q;
    logic              start_acc;
    logic              mismatch;
    logic              vld_q [RD_LAT];
    logic [DATA_W-1:0] exp_q [RD_LAT];

    function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] inc;
        logic [DATA_W-1:0] p;
        inc = DATA_W'(a) + DATA_W'(1);
        p   = '0;
        case (m)
            2'd0:    p = inc;
            2'd1:    p = ~inc;
            2'd2:    p = DATA_W'(1) << (int'(a) % DATA_W);
            default: for (int i = 0; i < DATA_W; i++) p[i] = a[0] ^ (i % 2 == 0);
        endcase
        return p;
    endfunction

    assign start_acc = start && (state == S_IDLE || state == S_DONE);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // phase sequencing: each phase ends on its own counter terminal value
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start)                         state_nx = S_WRITE;
            S_WRITE:        if (addr_cnt == '1)                state_nx = S_GAP;
            S_GAP:          if (wait_cnt == WC_W'(GAP - 1))    state_nx = S_READ;
            S_READ:         if (addr_cnt == '1)                state_nx = S_DRAIN;
            S_DRAIN:        if (wait_cnt == WC_W'(RD_LAT - 1)) state_nx = S_DONE;
            default:                                           state_nx = S_IDLE;
        endcase
    end

    // address sweeps wrap naturally from N-1 back to 0; wait counter times GAP and DRAIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt <= '0;
            wait_cnt <= '0;
            mode_q   <= 2'd0;
        end else begin
            addr_cnt <= (state == S_WRITE || state == S_READ) ? addr_cnt + 1'b1 : '0;
            wait_cnt <= ((state == S_GAP || state == S_DRAIN) && state_nx == state) ? wait_cnt + 1'b1 : '0;
            if (start_acc) mode_q <= mode;
        end
    end

    assign ram.wea   = (state == S_WRITE);
    assign ram.addra = (state == S_WRITE || state == S_READ) ? addr_cnt : '0;
    assign ram.dina  = (state == S_WRITE) ? pat(mode_q, addr_cnt) : '0;
    assign busy      = (state == S_WRITE || state == S_GAP || state == S_READ || state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign pass      = done && (err_cnt == 16'd0);

    // expected data travels alongside the RAM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_q[i] <= 1'b0;
                exp_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= (state == S_READ);
            exp_q[0] <= pat(mode_q, addr_cnt);
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                exp_q[i] <= exp_q[i-1];
            end
        end
    end

    assign mismatch = vld_q[RD_LAT-1] && (ram.douta != exp_q[RD_LAT-1]);

    // saturating mismatch counter, cleared when a new test is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    err_cnt <= 16'd0;
        else if (start_acc)                         err_cnt <= 16'd0;
        else if (mismatch && err_cnt != 16'hFFFF)   err_cnt <= err_cnt + 16'd1;
    end

`ifdef RAM_BIST_ERR_LOG_EN
    logic [ADDR_W-1:0] adr_q [RD_LAT];

    // read address delayed to line up with douta for the error log
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) adr_q[i] <= '0;
        end else begin
            adr_q[0] <= addr_cnt;
            for (int i = 1; i < RD_LAT; i++) adr_q[i] <= adr_q[i-1];
        end
    end

    // capture only the first mismatch of a test
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_addr <= '0;
            err_data <= '0;
        end else if (start_acc) begin
            err_addr <= '0;
            err_data <= '0;
        end else if (mismatch && err_cnt == 16'd0) begin
            err_addr <= adr_q[RD_LAT-1];
            err_data <= ram.douta;
        end
    end
`else
    assign err_addr = '0;
    assign err_data = '0;
`endif
endmodule

// File: tb/tb_ram_bist.sv
// tb/tb_ram_bist.sv - randomized self-checking bench for ram_bist against a behavioural RAM and pattern model
module tb_ram_bist;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;
    localparam int GAP    = 68;
    localparam int N      = 1 << ADDR_W;
    localparam int LAT    = 1 + N + GAP + N + RD_LAT;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic              busy, done, pass;
    logic [15:0]       err_cnt;
    logic [ADDR_W-1:0] err_addr;
    logic [DATA_W-1:0] err_data;

    int total = 0;
    int bad   = 0;

    ram_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram ();

    ram_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .GAP(GAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .ram      (ram),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .err_addr (err_addr),
        .err_data (err_data)
    );

    always #5 clk = ~clk;

    // ideal RAM with per-address read corruption mask
    logic [DATA_W-1:0] mem     [N];
    logic [DATA_W-1:0] flip    [N];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (ram.wea) mem[ram.addra] <= ram.dina;
        rd_pipe[0] <= mem[ram.addra] ^ flip[ram.addra];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram.douta = rd_pipe[RD_LAT-1];

    // write-port monitor
    int                wr_n = 0;
    int                dina_bad = 0;
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [DATA_W-1:0] wr_data_q [$];

    always @(negedge clk) begin
        if (ram.wea) begin
            wr_n++;
            wr_addr_q.push_back(ram.addra);
            wr_data_q.push_back(ram.dina);
        end else if (ram.dina != '0) begin
            dina_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] ref_pat(input int m, input int a);
        case (m)
            0:       return 8'((a + 1) % 256);
            1:       return 8'(255 - ((a + 1) % 256));
            2:       return 8'(1 << (a % 8));
            default: return (a % 2 == 0) ? 8'h55 : 8'hAA;
        endcase
    endfunction

    task automatic clear_mon();
        wr_n = 0;
        dina_bad = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic run_test(input int m, input bit repulse);
        int nerr = 0;
        int first = -1;
        int edges;
        int nord = 0;
        for (int a = 0; a < N; a++) begin
            if (flip[a] != 0) begin
                nerr++;
                if (first < 0) first = a;
            end
        end
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        mode  = 2'(m);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        mode  = 2'($urandom);
        chk("busy_acc", busy, 1);
        chk("done_acc", done, 0);
        chk("errcnt_acc", err_cnt, 0);
        while (!done && edges < LAT + 20) begin
            start = repulse && (edges == 10 || edges == 40);
            if (start) mode = 2'(m + 1 + edges % 3);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("latency", edges, LAT);
        chk("wr_count", wr_n, N);
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (int'(wr_addr_q[i]) != i || wr_data_q[i] != ref_pat(m, i)) nord++;
        chk("wr_order", nord, 0);
        chk("dina_idle", dina_bad, 0);
        if (m == 2 && wr_data_q.size() > 9) chk("m2_a9", wr_data_q[9], 8'h02);
        if (m == 3 && wr_data_q.size() > 5) begin
            chk("m3_a4", wr_data_q[4], 8'h55);
            chk("m3_a5", wr_data_q[5], 8'hAA);
        end
        chk("err_cnt", err_cnt, nerr);
        chk("pass", pass, (nerr == 0));
`ifdef RAM_BIST_ERR_LOG_EN
        chk("err_addr", err_addr, (first < 0) ? 0 : first);
        chk("err_data", err_data, (first < 0) ? 0 : ref_pat(m, first) ^ flip[first]);
`else
        chk("err_addr", err_addr, 0);
        chk("err_data", err_data, 0);
`endif
        @(negedge clk);
        chk("done_hold", done, 1);
    endtask

    task automatic clear_flip();
        for (int a = 0; a < N; a++) flip[a] = '0;
    endtask

    initial begin
        clear_flip();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_wea", ram.wea, 0);
        chk("rst_addra", ram.addra, 0);
        chk("rst_dina", ram.dina, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_errcnt", err_cnt, 0);
        chk("rst_erraddr", err_addr, 0);
        chk("rst_errdata", err_data, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_test(0, 0);
        run_test(2, 0);
        run_test(3, 0);

        flip[7]  = 8'h01;
        flip[20] = 8'h10;
        run_test(0, 0);

        clear_flip();
        run_test(1, 1);

        for (int t = 0; t < 4; t++) begin
            clear_flip();
            for (int a = 0; a < N; a++)
                if ($urandom % 8 == 0) flip[a] = 8'($urandom_range(1, 255));
            run_test(int'($urandom % 4), bit'($urandom % 2));
        end

        // abort in the middle of the read phase
        clear_flip();
        flip[2] = 8'h04;
        @(negedge clk);
        start = 1'b1;
        mode  = 2'd1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (110) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_addra", ram.addra, 10);
        chk("pre_rst_errcnt", err_cnt, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_wea", ram.wea, 0);
        chk("arst_addra", ram.addra, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_errcnt", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        repeat (40) @(negedge clk);
        chk("post_rst_wr", wr_n, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);

        clear_flip();
        run_test(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
